cache_req_stage: RTL and testbench

Parametrised first pipeline stage of the set-associative cache. Registers the incoming UFP request for the lookup stage and owns the miss FSM: dirty-victim writeback, line fill, and store-hit commit. Drives the tag/data/valid/dirty array write ports and the DFP interface. Victim selection is a tree-PLRU decoder generalised to any power-of-two way count.

---
 rtl/cache_types.sv | 31 +++
 rtl/plru_victim.sv | 39 +++
 rtl/cache_req_stage.sv | 194 +++++++++++++++++++
 tb/tb_cache_req_stage.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared types for the cache request/lookup pipeline
//
// Contents:
//   state_t : miss/commit FSM encoding used by cache_req_stage
//   idx_w   : index width for a power-of-two count (never below 1)
//   sr_t    : stage register handed from the request stage to the lookup stage
package cache_types;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        WCOMMIT = 3'd1,
        WB      = 3'd2,
        FILL    = 3'd3,
        REPLAY  = 3'd4
    } state_t;

    // A single-entry structure still needs a one-bit index so port
    // declarations never collapse to zero width.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } sr_t;

endpackage

// File: rtl/plru_victim.sv
// rtl/plru_victim.sv - combinational tree-PLRU victim decoder
//
// Ports:
//   plru_bits  in  WAYS-1 : PLRU tree for one set, heap order (node 0 = root)
//   victim_way out WAY_W  : leaf reached by walking the tree from the root
//
// A node bit of 1 steers the walk to the lower half (child 2i+1), a 0 to
// the upper half (child 2i+2). Shared with the PLRU update in stage 2.
module plru_victim
    import cache_types::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = idx_w(WAYS)
) (
    input  logic [WAYS-2:0]  plru_bits,
    output logic [WAY_W-1:0] victim_way
);

    // The tree is padded to 2*WAYS entries so the walk can index it with a
    // WAY_W+1 bit node number without range concerns; the pad is never read
    // because the walk stops after WAY_W levels, at a leaf.
    logic [2*WAYS-1:0] tree;
    logic [WAY_W:0]    node;

    always_comb begin
        tree = {{(WAYS+1){1'b0}}, plru_bits};
        node = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            if (tree[node]) begin
                node = (node << 1) + (WAY_W+1)'(1);
            end else begin
                node = (node << 1) + (WAY_W+1)'(2);
            end
        end
        // Leaves occupy heap slots WAYS-1 .. 2*WAYS-2.
        victim_way = WAY_W'(node - (WAY_W+1)'(WAYS-1));
    end

endmodule

// File: rtl/cache_req_stage.sv
// rtl/cache_req_stage.sv - cache request stage: stage register and miss FSM
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   ufp_addr/rmask/wmask/wdata  in   : CPU request, valid when a mask is nonzero
//   ufp_ready                   out  : request captured this cycle
//   sr_valid/addr/rmask/wmask/wdata  : stage register to the lookup stage
//   lk_hit, lk_hit_way          in   : lookup result for the stage register
//   lk_victim_dirty/tag/data    in   : array contents of the victim way
//   plru_bits                   in   : PLRU tree for the looked-up set
//   arr_web                     out  : per-way array write enable, active low
//   arr_wmask/data_in/tag_in    out  : array write byte mask, data, tag
//   arr_valid_in/dirty_in       out  : valid/dirty write values
//   dfp_addr/read/write/wdata   out  : line-level memory request
//   dfp_rdata, dfp_resp         in   : memory read data, transfer complete
//
// All outputs depend on the FSM state, the stage register and the lookup
// results only; ufp_* reaches nothing but the stage register input.
module cache_req_stage
    import cache_types::*;
#(
    parameter  int WAYS      = 4,
    parameter  int SETS      = 16,
    parameter  int LINE_BITS = 256,
    localparam int BYTES     = LINE_BITS / 8,
    localparam int OFF_W     = idx_w(BYTES),
    localparam int SET_W     = idx_w(SETS),
    localparam int TAG_W     = 32 - SET_W - OFF_W,
    localparam int WAY_W     = idx_w(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          ufp_addr,
    input  logic [3:0]           ufp_rmask,
    input  logic [3:0]           ufp_wmask,
    input  logic [31:0]          ufp_wdata,
    output logic                 ufp_ready,

    output logic                 sr_valid,
    output logic [31:0]          sr_addr,
    output logic [3:0]           sr_rmask,
    output logic [3:0]           sr_wmask,
    output logic [31:0]          sr_wdata,

    input  logic                 lk_hit,
    input  logic [WAY_W-1:0]     lk_hit_way,
    input  logic                 lk_victim_dirty,
    input  logic [TAG_W-1:0]     lk_victim_tag,
    input  logic [LINE_BITS-1:0] lk_victim_data,
    input  logic [WAYS-2:0]      plru_bits,

    output logic [WAYS-1:0]      arr_web,
    output logic [BYTES-1:0]     arr_wmask,
    output logic [LINE_BITS-1:0] arr_data_in,
    output logic [TAG_W-1:0]     arr_tag_in,
    output logic                 arr_valid_in,
    output logic                 arr_dirty_in,

    output logic [31:0]          dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [LINE_BITS-1:0] dfp_wdata,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp
);

    state_t           state_q, state_d;
    sr_t              sr_q, sr_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [WAY_W-1:0] victim_way;

    logic             ufp_req;
    logic             sr_store;
    logic [TAG_W-1:0] sr_tag;
    logic [SET_W-1:0] sr_set;
    logic [OFF_W-3:0] sr_word;

    plru_victim #(
        .WAYS       (WAYS)
    ) u_plru_victim (
        .plru_bits  (plru_bits),
        .victim_way (victim_way)
    );

    assign ufp_req  = (|ufp_rmask) | (|ufp_wmask);
    assign sr_store = |sr_q.wmask;
    assign sr_tag   = sr_q.addr[31 -: TAG_W];
    assign sr_set   = sr_q.addr[OFF_W +: SET_W];
    assign sr_word  = sr_q.addr[2 +: OFF_W-2];

    assign sr_valid = sr_q.valid;
    assign sr_addr  = sr_q.addr;
    assign sr_rmask = sr_q.rmask;
    assign sr_wmask = sr_q.wmask;
    assign sr_wdata = sr_q.wdata;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        victim_d     = victim_q;
        ufp_ready    = 1'b0;
        arr_web      = '1;
        arr_wmask    = '0;
        arr_data_in  = '0;
        arr_tag_in   = '0;
        arr_valid_in = 1'b0;
        arr_dirty_in = 1'b0;
        dfp_addr     = '0;
        dfp_read     = 1'b0;
        dfp_write    = 1'b0;
        dfp_wdata    = '0;

        case (state_q)
            RUN: begin
                if (!sr_q.valid || (lk_hit && !sr_store)) begin
                    // Free-running capture; an empty request becomes a bubble.
                    ufp_ready  = !rst;
                    sr_d.valid = ufp_req;
                    sr_d.addr  = ufp_addr;
                    sr_d.rmask = ufp_rmask;
                    sr_d.wmask = ufp_wmask;
                    sr_d.wdata = ufp_wdata;
                end else if (lk_hit) begin
                    state_d = WCOMMIT;
                end else begin
                    // Latch the victim now: the PLRU input may change once the
                    // fill lands, but the fill must go to the way chosen here.
                    victim_d = victim_way;
                    state_d  = lk_victim_dirty ? WB : FILL;
                end
            end

            WCOMMIT: begin
                arr_web[lk_hit_way] = 1'b0;
                arr_wmask           = BYTES'(sr_q.wmask) << {sr_word, 2'b00};
                arr_data_in         = LINE_BITS'(sr_q.wdata) << {sr_word, 5'b00000};
                arr_tag_in          = sr_tag;
                arr_valid_in        = 1'b1;
                arr_dirty_in        = 1'b1;
                // Dropping valid keeps the committed store from being replayed.
                sr_d.valid          = 1'b0;
                state_d             = RUN;
            end

            WB: begin
                // Stage register holds, so lk_victim_* stay stable until the
                // memory acknowledges the writeback.
                dfp_write = 1'b1;
                dfp_addr  = {lk_victim_tag, sr_set, {OFF_W{1'b0}}};
                dfp_wdata = lk_victim_data;
                if (dfp_resp) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                dfp_read = 1'b1;
                dfp_addr = {sr_tag, sr_set, {OFF_W{1'b0}}};
                if (dfp_resp) begin
                    arr_web[victim_q] = 1'b0;
                    arr_wmask         = '1;
                    arr_data_in       = dfp_rdata;
                    arr_tag_in        = sr_tag;
                    arr_valid_in      = 1'b1;
                    arr_dirty_in      = 1'b0;
                    state_d           = REPLAY;
                end
            end

            REPLAY: begin
                // One idle cycle so the arrays present the freshly filled line.
                state_d = RUN;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            sr_q     <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            victim_q <= victim_d;
        end
    end

endmodule

// File: tb/tb_cache_req_stage.sv
// tb/tb_cache_req_stage.sv - self-checking bench for cache_req_stage
module tb_cache_req_stage;

    logic         clk = 1'b0;
    logic         rst;

    logic [31:0]  ufp_addr, ufp_wdata;
    logic [3:0]   ufp_rmask, ufp_wmask;
    logic [3:0]   u2_rmask, u2_wmask;

    // default instance: WAYS 4, SETS 16, LINE_BITS 256 (TAG_W 23)
    logic         ufp_ready;
    logic         sr_valid;
    logic [31:0]  sr_addr, sr_wdata;
    logic [3:0]   sr_rmask, sr_wmask;
    logic         lk_hit, lk_victim_dirty;
    logic [1:0]   lk_hit_way;
    logic [22:0]  lk_victim_tag;
    logic [255:0] lk_victim_data;
    logic [2:0]   plru_bits;
    logic [3:0]   arr_web;
    logic [31:0]  arr_wmask;
    logic [255:0] arr_data_in;
    logic [22:0]  arr_tag_in;
    logic         arr_valid_in, arr_dirty_in;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write, dfp_resp;
    logic [255:0] dfp_wdata, dfp_rdata;

    // wide instance: WAYS 8, SETS 64, LINE_BITS 512 (TAG_W 20)
    logic         ufp_ready2;
    logic         sr2_valid;
    logic [31:0]  sr2_addr, sr2_wdata;
    logic [3:0]   sr2_rmask, sr2_wmask;
    logic         lk2_hit, lk2_victim_dirty;
    logic [2:0]   lk2_hit_way;
    logic [19:0]  lk2_victim_tag;
    logic [511:0] lk2_victim_data;
    logic [6:0]   plru2;
    logic [7:0]   arr2_web;
    logic [63:0]  arr2_wmask;
    logic [511:0] arr2_data_in;
    logic [19:0]  arr2_tag_in;
    logic         arr2_valid_in, arr2_dirty_in;
    logic [31:0]  dfp2_addr;
    logic         dfp2_read, dfp2_write, dfp2_resp;
    logic [511:0] dfp2_wdata, dfp2_rdata;

    int checks = 0;
    int errors = 0;

    cache_req_stage u_dut (
        .clk(clk), .rst(rst),
        .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
        .ufp_wdata(ufp_wdata), .ufp_ready(ufp_ready),
        .sr_valid(sr_valid), .sr_addr(sr_addr), .sr_rmask(sr_rmask),
        .sr_wmask(sr_wmask), .sr_wdata(sr_wdata),
        .lk_hit(lk_hit), .lk_hit_way(lk_hit_way), .lk_victim_dirty(lk_victim_dirty),
        .lk_victim_tag(lk_victim_tag), .lk_victim_data(lk_victim_data),
        .plru_bits(plru_bits),
        .arr_web(arr_web), .arr_wmask(arr_wmask), .arr_data_in(arr_data_in),
        .arr_tag_in(arr_tag_in), .arr_valid_in(arr_valid_in), .arr_dirty_in(arr_dirty_in),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
    );

    cache_req_stage #(.WAYS(8), .SETS(64), .LINE_BITS(512)) u_dut_wide (
        .clk(clk), .rst(rst),
        .ufp_addr(ufp_addr), .ufp_rmask(u2_rmask), .ufp_wmask(u2_wmask),
        .ufp_wdata(ufp_wdata), .ufp_ready(ufp_ready2),
        .sr_valid(sr2_valid), .sr_addr(sr2_addr), .sr_rmask(sr2_rmask),
        .sr_wmask(sr2_wmask), .sr_wdata(sr2_wdata),
        .lk_hit(lk2_hit), .lk_hit_way(lk2_hit_way), .lk_victim_dirty(lk2_victim_dirty),
        .lk_victim_tag(lk2_victim_tag), .lk_victim_data(lk2_victim_data),
        .plru_bits(plru2),
        .arr_web(arr2_web), .arr_wmask(arr2_wmask), .arr_data_in(arr2_data_in),
        .arr_tag_in(arr2_tag_in), .arr_valid_in(arr2_valid_in), .arr_dirty_in(arr2_dirty_in),
        .dfp_addr(dfp2_addr), .dfp_read(dfp2_read), .dfp_write(dfp2_write),
        .dfp_wdata(dfp2_wdata), .dfp_rdata(dfp2_rdata), .dfp_resp(dfp2_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Victim by range halving: each tree bit of 1 keeps the lower half.
    function automatic int model_victim(input int ways, input int bits);
        int lo, hi, node, mid;
        lo = 0; hi = ways; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (((bits >> node) & 1) == 1) begin
                hi = mid; node = 2 * node + 1;
            end else begin
                lo = mid; node = 2 * node + 2;
            end
        end
        return lo;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_excl", {1'b0, dfp_read & dfp_write}, 2'b00);
            check("rd_wr_excl_wide", {1'b0, dfp2_read & dfp2_write}, 2'b00);
        end
    end

    // kind: 0 read hit, 1 store hit, 2 clean miss, 3 dirty miss
    task automatic run_txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                           input logic [31:0] wd, input int kind, input int way,
                           input logic [2:0] pl, input logic [22:0] vtag, input int dly);
        logic [255:0] vdata, rdata;
        logic [3:0]   ew;
        logic [31:0]  em, wbaddr, line;
        int           vic, w;
        vdata  = 256'(rand_line());
        rdata  = 256'(rand_line());
        vic    = model_victim(4, int'(pl));
        line   = {a[31:5], 5'b0};
        wbaddr = {vtag, a[8:5], 5'b0};

        ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
        @(negedge clk);
        check("bubble_before", sr_valid, 1'b0);
        check("ready_accept", ufp_ready, 1'b1);
        tick();

        ufp_rmask = 4'h0; ufp_wmask = 4'h0;
        lk_hit = (kind < 2); lk_hit_way = 2'(way); lk_victim_dirty = (kind == 3);
        lk_victim_tag = vtag; lk_victim_data = vdata; plru_bits = pl;
        @(negedge clk);
        check("sr_valid", sr_valid, 1'b1);
        check("sr_addr", sr_addr, a);
        check("sr_rmask", sr_rmask, rm);
        check("sr_wmask", sr_wmask, wm);
        check("sr_wdata", sr_wdata, wd);
        if (kind == 0) begin
            check("rdhit_ready", ufp_ready, 1'b1);
            check("rdhit_web", arr_web, 4'hF);
            check("rdhit_dfp", {dfp_read, dfp_write}, 2'b00);
            tick();
            return;
        end
        check("stall_ready", ufp_ready, 1'b0);
        tick();

        if (kind >= 2) begin
            if (kind == 3) begin
                for (int i = 0; i <= dly; i++) begin
                    if (i == dly) dfp_resp = 1'b1;
                    @(negedge clk);
                    if (i < dly) check("wb_write", dfp_write, 1'b1);
                    check("wb_noread", dfp_read, 1'b0);
                    check("wb_addr", dfp_addr, wbaddr);
                    check("wb_wdata", dfp_wdata, vdata);
                    check("wb_web", arr_web, 4'hF);
                    check("wb_sr_hold", sr_addr, a);
                    tick();
                end
                dfp_resp = 1'b0;
            end
            for (int i = 0; i <= dly; i++) begin
                if (i == dly) begin dfp_resp = 1'b1; dfp_rdata = rdata; end
                @(negedge clk);
                if (i < dly) check("fill_read", dfp_read, 1'b1);
                check("fill_nowrite", dfp_write, 1'b0);
                check("fill_addr", dfp_addr, line);
                if (i < dly) begin
                    check("fill_web_idle", arr_web, 4'hF);
                end else begin
                    ew = ~(4'b0001 << vic);
                    check("fill_web", arr_web, ew);
                    check("fill_wmask", arr_wmask, 32'hFFFF_FFFF);
                    check("fill_data", arr_data_in, rdata);
                    check("fill_tag", arr_tag_in, a[31:9]);
                    check("fill_vd", {arr_valid_in, arr_dirty_in}, 2'b10);
                end
                tick();
            end
            dfp_resp = 1'b0;

            @(negedge clk);
            check("replay_web", arr_web, 4'hF);
            check("replay_dfp", {dfp_read, dfp_write}, 2'b00);
            check("replay_ready", ufp_ready, 1'b0);
            check("replay_sr", sr_valid, 1'b1);
            tick();

            lk_hit = 1'b1; lk_hit_way = 2'(vic); lk_victim_dirty = 1'b0; way = vic;
            @(negedge clk);
            check("rehit_sr", sr_addr, a);
            if (wm == 4'h0) begin
                check("rehit_ready", ufp_ready, 1'b1);
                tick();
                lk_hit = 1'b0;
                return;
            end
            check("rehit_stall", ufp_ready, 1'b0);
            tick();
        end

        w  = int'(a[4:2]);
        em = '0;
        for (int b = 0; b < 4; b++) if (wm[b]) em[w*4 + b] = 1'b1;
        ew = ~(4'b0001 << way);
        @(negedge clk);
        check("wc_web", arr_web, ew);
        check("wc_wmask", arr_wmask, em);
        check("wc_data", arr_data_in[w*32 +: 32], wd);
        check("wc_tag", arr_tag_in, a[31:9]);
        check("wc_vd", {arr_valid_in, arr_dirty_in}, 2'b11);
        check("wc_ready", ufp_ready, 1'b0);
        tick();
        lk_hit = 1'b0;
    endtask

    task automatic run_wide(input logic [6:0] pl);
        logic [31:0]  a;
        logic [511:0] rd;
        logic [7:0]   ew;
        int           vic;
        a   = $urandom;
        rd  = rand_line();
        vic = model_victim(8, int'(pl));
        ew  = ~(8'h01 << vic);
        ufp_addr = a; u2_rmask = 4'hF;
        @(negedge clk);
        check("w_ready", ufp_ready2, 1'b1);
        tick();
        u2_rmask = 4'h0; lk2_hit = 1'b0; lk2_victim_dirty = 1'b0; plru2 = pl;
        @(negedge clk);
        check("w_stall", ufp_ready2, 1'b0);
        tick();
        @(negedge clk);
        check("w_read", dfp2_read, 1'b1);
        check("w_addr", dfp2_addr, {a[31:6], 6'b0});
        check("w_addr_low", dfp2_addr[5:0], 6'b0);
        tick();
        dfp2_resp = 1'b1; dfp2_rdata = rd;
        @(negedge clk);
        check("w_web", arr2_web, ew);
        check("w_data", arr2_data_in, rd);
        check("w_tag", arr2_tag_in, a[31:12]);
        tick();
        dfp2_resp = 1'b0;
        @(negedge clk);
        check("w_replay_web", arr2_web, 8'hFF);
        tick();
        lk2_hit = 1'b1;
        @(negedge clk);
        check("w_rehit_ready", ufp_ready2, 1'b1);
        tick();
        lk2_hit = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, prev;
        logic [3:0]  rm, wm;
        int          kind;

        rst = 1'b1;
        ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
        u2_rmask = '0; u2_wmask = '0;
        lk_hit = 1'b0; lk_hit_way = '0; lk_victim_dirty = 1'b0; lk_victim_tag = '0;
        lk_victim_data = '0; plru_bits = '0; dfp_rdata = '0; dfp_resp = 1'b0;
        lk2_hit = 1'b0; lk2_hit_way = '0; lk2_victim_dirty = 1'b0; lk2_victim_tag = '0;
        lk2_victim_data = '0; plru2 = '0; dfp2_rdata = '0; dfp2_resp = 1'b0;
        prev = '0;

        tick();
        @(negedge clk);
        check("rst_ready", ufp_ready, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_sr_valid", sr_valid, 1'b0);
        check("rst_sr_addr", sr_addr, 32'h0);
        check("rst_web", arr_web, 4'hF);
        check("rst_wmask", arr_wmask, 32'h0);
        check("rst_dfp", {dfp_read, dfp_write}, 2'b00);
        check("rst_dfp_addr", dfp_addr, 32'h0);
        check("rst_ready_after", ufp_ready, 1'b1);
        tick();

        run_txn(32'h0000_1234, 4'hF, 4'h0, 32'h0, 0, 2, 3'b000, 23'h0, 0);
        run_txn(32'h0000_0048, 4'h0, 4'b0011, 32'hAABB_CCDD, 1, 1, 3'b000, 23'h0, 0);
        run_txn(32'h0000_0200, 4'hF, 4'h0, 32'h0, 2, 0, 3'b100, 23'h0, 5);
        run_txn(32'h0000_4064, 4'hF, 4'h0, 32'h0, 3, 0, 3'b011, 23'h000001, 3);

        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            ufp_addr = a; ufp_rmask = 4'($urandom_range(1, 15)); ufp_wmask = 4'h0;
            lk_hit = 1'b1; lk_hit_way = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("b2b_ready", ufp_ready, 1'b1);
            if (k > 0) check("b2b_sr_addr", sr_addr, prev);
            check("b2b_web", arr_web, 4'hF);
            prev = a;
            tick();
        end
        ufp_rmask = 4'h0;
        @(negedge clk);
        check("b2b_last", sr_addr, prev);
        check("b2b_last_valid", sr_valid, 1'b1);
        tick();
        lk_hit = 1'b0;

        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            if (kind == 0 || (kind >= 2 && $urandom_range(0, 1) == 1)) begin
                rm = 4'($urandom_range(1, 15)); wm = 4'h0;
            end else begin
                rm = 4'h0; wm = 4'($urandom_range(1, 15));
            end
            run_txn(a, rm, wm, $urandom, kind, int'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 23'($urandom), int'($urandom_range(0, 4)));
        end

        ufp_addr = 32'h0000_0740; ufp_rmask = 4'hF;
        @(negedge clk);
        tick();
        ufp_rmask = 4'h0; lk_hit = 1'b0; lk_victim_dirty = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rstfill_read", dfp_read, 1'b1);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstfill_ready", ufp_ready, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstfill_dfp_read", dfp_read, 1'b0);
        check("rstfill_dfp_addr", dfp_addr, 32'h0);
        check("rstfill_sr_valid", sr_valid, 1'b0);
        check("rstfill_web", arr_web, 4'hF);
        check("rstfill_run_ready", ufp_ready, 1'b1);
        tick();
        dfp_resp = 1'b1; dfp_rdata = 256'(rand_line());
        @(negedge clk);
        check("stale_resp_web", arr_web, 4'hF);
        check("stale_resp_read", dfp_read, 1'b0);
        tick();
        dfp_resp = 1'b0;

        run_wide(7'b0000000);
        for (int n = 0; n < 4; n++) run_wide(7'($urandom_range(0, 127)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
